// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO, one result bit per cycle.
// Signed MULT/DIV is built only when MDU_SIGNED_EN is defined.
module mult_div_unit #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  start_in,
    input  logic [1:0]            op_in,
    input  logic [DATA_WIDTH-1:0] operand_a_in,
    input  logic [DATA_WIDTH-1:0] operand_b_in,
    input  logic                  write_hi_in,
    input  logic                  write_lo_in,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  div_by_zero_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t         state_q;
    logic           is_div_q;
    logic           neg_res_q;
    logic           neg_rem_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           busy_q;
    logic           done_q;
    logic           dbz_q;

    logic           sgn_a;
    logic           sgn_b;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] acc_d;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic           div_ge;
    logic [W-1:0]   rem_d;
    logic [W-1:0]   quo_d;
    logic [CW-1:0]  cnt_d;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic           b_zero;

`ifdef MDU_SIGNED_EN
    // Operand signs and magnitudes captured when a start is accepted
    always_comb begin
        sgn_a = op_in[0] & operand_a_in[W-1];
        sgn_b = op_in[0] & operand_b_in[W-1];
        mag_a = sgn_a ? -operand_a_in : operand_a_in;
        mag_b = sgn_b ? -operand_b_in : operand_b_in;
    end
`else
    logic op_sign_unused;
    assign op_sign_unused = op_in[0];

    // Unsigned-only build: operands pass straight through
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        mag_a = operand_a_in;
        mag_b = operand_b_in;
    end
`endif

    // One shift-add / restoring-subtract step plus the final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]}
                  + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        acc_d     = {mul_sum, acc_q[W-1:1]};
        div_shift = {rem_q, quo_q[W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[W];
        rem_d     = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
        quo_d     = {quo_q[W-2:0], div_ge};
        cnt_d     = cnt_q - CW'(1);
        b_zero    = (b_q == '0);
        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -quo_q : quo_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
    end

    // Control FSM with datapath and registered outputs
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        is_div_q  <= op_in[1];
                        neg_res_q <= sgn_a ^ sgn_b;
                        neg_rem_q <= sgn_a;
                        // Divides keep the raw dividend for the
                        // divide-by-zero HI value; multiplies need |a|.
                        a_q       <= op_in[1] ? operand_a_in : mag_a;
                        b_q       <= mag_b;
                        acc_q     <= {{W{1'b0}}, mag_b};
                        rem_q     <= '0;
                        quo_q     <= mag_a;
                        cnt_q     <= CW'(W);
                        busy_q    <= 1'b1;
                        dbz_q     <= 1'b0;
                        state_q   <= S_CALC;
                    end else begin
                        if (write_hi_in) hi_q <= write_data_in;
                        if (write_lo_in) lo_q <= write_data_in;
                    end
                end
                S_CALC: begin
                    if (is_div_q) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                    end else begin
                        acc_q <= acc_d;
                    end
                    cnt_q <= cnt_d;
                    if (cnt_q == CW'(1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end else if (b_zero) begin
                        hi_q  <= a_q;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi_out          = hi_q;
    assign lo_out          = lo_q;
    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign div_by_zero_out = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with an expected-result queue.
// Expectations follow MDU_SIGNED_EN the same way the design build does.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [15:0] wdata;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        busy;
    logic        done;
    logic        dbz;

    int n_pass  = 0;
    int n_total = 0;

    logic [32:0] sb_q[$];
    logic [15:0] cur_hi;
    logic [15:0] cur_lo;

    mult_div_unit #(.DATA_WIDTH(16)) dut (
        .clock_in        (clk),
        .reset_n_in      (rst_n),
        .start_in        (start),
        .op_in           (op),
        .operand_a_in    (a),
        .operand_b_in    (b),
        .write_hi_in     (wr_hi),
        .write_lo_in     (wr_lo),
        .write_data_in   (wdata),
        .hi_out          (hi),
        .lo_out          (lo),
        .busy_out        (busy),
        .done_out        (done),
        .div_by_zero_out (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h",
                    tag, obs, exp);
    endtask

    // Reference result {dbz, hi, lo} from native arithmetic
    function automatic logic [32:0] model(input logic [1:0]  o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        logic   sg;
        longint sx, sy, p, q, r;
        logic [63:0] pv, qv, rv;
`ifdef MDU_SIGNED_EN
        sg = o[0];
`else
        sg = 1'b0;
`endif
        sx = sg ? longint'({{48{x[15]}}, x}) : longint'({48'b0, x});
        sy = sg ? longint'({{48{y[15]}}, y}) : longint'({48'b0, y});
        if (!o[1]) begin
            p  = sx * sy;
            pv = p;
            return {1'b0, pv[31:16], pv[15:0]};
        end
        if (y == 16'h0) return {1'b1, x, 16'hFFFF};
        q  = sx / sy;
        r  = sx % sy;
        qv = q;
        rv = r;
        return {1'b0, rv[15:0], qv[15:0]};
    endfunction

    // Issue one operation and check its whole lifetime
    task automatic run_op(input logic [1:0]  o,
                          input logic [15:0] x,
                          input logic [15:0] y,
                          input bit          hazard,
                          input bit          wr_at_start);
        int          busy_n;
        bit          got;
        logic [32:0] e;
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (wr_at_start) begin
            wr_hi = 1'b1;
            wdata = 16'hBEEF;
        end
        sb_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        start  = 1'b0;
        wr_hi  = 1'b0;
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (i == 0) begin
                check("dbz_clear", {31'b0, dbz}, 32'd0);
                check("hi_hold", {16'b0, hi}, {16'b0, cur_hi});
                check("lo_hold", {16'b0, lo}, {16'b0, cur_lo});
            end
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_n++;
                if (hazard && i == 4) begin
                    start = 1'b1;
                    op    = ~o;
                    a     = 16'h0F0F;
                    b     = 16'h0003;
                    wr_hi = 1'b1;
                    wdata = 16'hAAAA;
                end
                if (hazard && i == 5) begin
                    start = 1'b0;
                    wr_hi = 1'b0;
                    check("hz_hi", {16'b0, hi}, {16'b0, cur_hi});
                end
                @(posedge clk);
                #1;
            end
        end
        check("done_seen", {31'b0, got}, 32'd1);
        check("busy_cycles", busy_n, 32'd17);
        check("busy_in_done", {31'b0, busy}, 32'd0);
        e = sb_q.pop_front();
        check("hi", {16'b0, hi}, {16'b0, e[31:16]});
        check("lo", {16'b0, lo}, {16'b0, e[15:0]});
        check("dbz", {31'b0, dbz}, {31'b0, e[32]});
        cur_hi = e[31:16];
        cur_lo = e[15:0];
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hi"}, {16'b0, hi}, 32'd0);
        check({tag, "_lo"}, {16'b0, lo}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_dbz"}, {31'b0, dbz}, 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        wdata  = '0;
        cur_hi = '0;
        cur_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 16'hFFFF, 16'hFFFF, 0, 0);
        check("plan_mul_hi", {16'b0, hi}, 32'h0000_FFFE);
        check("plan_mul_lo", {16'b0, lo}, 32'h0000_0001);
        run_op(2'b01, 16'hFFFD, 16'h0005, 0, 0);
        run_op(2'b11, 16'hFFF9, 16'h0002, 0, 0);
        run_op(2'b10, 16'd100, 16'd7, 0, 0);
        check("plan_divu_lo", {16'b0, lo}, 32'h0000_000E);
        run_op(2'b10, 16'h1234, 16'h0000, 0, 0);
        check("plan_dbz_hi", {16'b0, hi}, 32'h0000_1234);
        run_op(2'b11, 16'h8000, 16'hFFFF, 0, 0);
        run_op(2'b00, 16'h1234, 16'h5678, 1, 0);
        check("hz_not_aaaa", {31'b0, hi === 16'hAAAA}, 32'd0);

        // Hazard start must not have queued a second operation
        repeat (3) @(posedge clk);
        #1;
        check("no_extra_busy", {31'b0, busy}, 32'd0);

        @(negedge clk);
        wr_lo = 1'b1;
        wdata = 16'h5555;
        @(posedge clk);
        #1;
        wr_lo  = 1'b0;
        cur_lo = 16'h5555;
        check("mtlo", {16'b0, lo}, 32'h0000_5555);
        @(negedge clk);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 16'hC3C3;
        @(posedge clk);
        #1;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        cur_hi = 16'hC3C3;
        cur_lo = 16'hC3C3;
        check("mthi_both", {16'b0, hi}, 32'h0000_C3C3);
        check("mtlo_both", {16'b0, lo}, 32'h0000_C3C3);

        run_op(2'b01, 16'h7FFF, 16'h8000, 0, 1);

        for (int k = 0; k < 6; k++) begin
            run_op(2'($urandom_range(0, 3)),
                   16'($urandom), 16'($urandom), 0, 0);
        end

        // Reset in the middle of a calculation
        @(negedge clk);
        op    = 2'b00;
        a     = 16'h00FF;
        b     = 16'h0101;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n  = 1'b1;
        cur_hi = '0;
        cur_lo = '0;
        run_op(2'b11, 16'h8000, 16'h0003, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the register file in the non-pipelined MIPS datapath. It consumes the two register-file read ports (rs → operand_a_in, rt → operand_b_in) for MULT/MULTU/DIV/DIVU and holds the results in HI/LO for MFHI/MFLO. MTHI/MTLO writes are also supported. One result bit is produced per cycle, and a start/busy/done handshake lets the control unit stall while the operation runs.

## Interface
- DATA_WIDTH, 16, operand and HI/LO width (W); must be ≥ 2
- clock_in  input  1  clock, all state updates on rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  request an operation; sampled only in IDLE
- op_in  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- operand_a_in  input  W  rs data (multiplicand / dividend)
- operand_b_in  input  W  rt data (multiplier / divisor)
- write_hi_in  input  1  MTHI strobe
- write_lo_in  input  1  MTLO strobe
- write_data_in  input  W  MTHI/MTLO data
- hi_out  output  W  HI register (upper product / remainder)
- lo_out  output  W  LO register (lower product / quotient)
- busy_out  output  1  high while an operation is in progress
- done_out  output  1  one-cycle pulse after HI/LO are updated by an operation
- div_by_zero_out  output  1  last completed divide had divisor 0

## Operation
- Reset (async, reset_n_in=0): state IDLE; hi_out=0, lo_out=0, busy_out=0, done_out=0, div_by_zero_out=0; counter and working registers cleared. A reset during CALC/FIX aborts the operation with no HI/LO update.
- FSM states: IDLE, CALC, FIX.
- IDLE → CALC when start_in=1 at an edge:
  - Latch op.
  - For signed ops, latch the magnitudes |a| and |b| (as W-bit unsigned) and the operand signs.
  - Set counter to W.
  - Clear div_by_zero_out.
- CALC: one step per edge, counter decrements; after W steps → FIX.
  - Multiply: shift-add, 2W-bit accumulator.
  - Divide: restoring, W-bit remainder plus one guard bit, W-bit quotient.
- FIX → IDLE: apply signs, write HI/LO, assert done_out for the next cycle.
  - MULT: the 2W product is negated if the signs differ; HI = upper W bits, LO = lower W bits.
  - DIV: quotient negated if the signs differ (truncation toward zero); remainder takes the sign of the dividend.
  - Overflow case (most-negative ÷ −1): LO = most-negative value, HI = 0. No trap.
- Divisor 0: latency is unchanged. Result LO = all ones, HI = operand_a_in as latched (raw, unsigned/un-negated). div_by_zero_out=1 from the FIX edge until the next accepted start.
- MTHI/MTLO:
  - In IDLE, write_hi_in/write_lo_in load write_data_in at the edge; both may be asserted together.
  - They are ignored in CALC/FIX.
  - If start_in and a write strobe are asserted at the same edge, start wins and the write is dropped.
- start_in outside IDLE is ignored, and the operands of the running operation are unaffected.
- hi_out/lo_out are stable throughout CALC and change only at the FIX edge or an MTHI/MTLO edge.

## Timing
- Start accepted at edge N; busy_out=1 from just after edge N until just after edge N+W+1.
- CALC occupies edges N+1..N+W; FIX edge is N+W+1, at which HI/LO update.
- done_out=1 for exactly the cycle following edge N+W+1, with busy_out=0 in that cycle. Total latency is W+1 cycles (17 for W=16).
- A new start may be accepted at the edge ending the done_out cycle (back-to-back operations).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MDU_SIGNED_EN defined: MULT and DIV perform signed arithmetic as described above; op_in[0] selects signed.
- MDU_SIGNED_EN undefined: the sign-handling logic is removed and op_in[0] is ignored. MULT behaves as MULTU and DIV as DIVU. Latency and the divide-by-zero rule are unchanged.

## Test plan
- Reset, then MULTU 0xFFFF×0xFFFF, start at edge 0 → busy_out for 17 cycles; done_out in the cycle after edge 17; HI=0xFFFE, LO=0x0001.
- MULT 0xFFFD (−3) × 0x0005 → HI=0xFFFF, LO=0xFFF1. Without MDU_SIGNED_EN → HI=0x0004, LO=0xFFF1.
- DIV 0xFFF9 (−7) ÷ 0x0002 → LO=0xFFFD, HI=0xFFFF. DIVU 100 ÷ 7 → LO=0x000E, HI=0x0002, div_by_zero_out=0.
- DIVU 0x1234 ÷ 0 → after 17 cycles LO=0xFFFF, HI=0x1234, div_by_zero_out=1. The next start clears the flag.
- DIV 0x8000 ÷ 0xFFFF → LO=0x8000, HI=0x0000, no other side effects.
- Hazards:
  - During CALC, pulse start_in with new operands and assert write_hi_in with 0xAAAA → result matches the original operation and HI is not 0xAAAA.
  - In IDLE, write_lo_in with 0x5555 → lo_out=0x5555 after one edge.
  - Drop reset_n_in mid-CALC → all outputs 0 immediately; the next operation runs normally.
